// File: rtl/mole_game_pkg.sv
// Shared types and constants for the whack-a-mole game controller.
package mole_game_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_OVER = 2'd2
   } game_state_t;

   localparam int NUM_POS = 5;

   // Mole cell codes, also used as indices into the press vector
   localparam logic [2:0] POS_UP     = 3'd0;
   localparam logic [2:0] POS_LEFT   = 3'd1;
   localparam logic [2:0] POS_MIDDLE = 3'd2;
   localparam logic [2:0] POS_RIGHT  = 3'd3;
   localparam logic [2:0] POS_DOWN   = 3'd4;

   localparam int BTN_UP     = 0;
   localparam int BTN_LEFT   = 1;
   localparam int BTN_MIDDLE = 2;
   localparam int BTN_RIGHT  = 3;
   localparam int BTN_DOWN   = 4;

   // Feedback taps 8,6,5,4 (bits 7,5,4,3)
   localparam logic [7:0] LFSR_TAPS = 8'hB8;

   // Two BCD digits of a 0..99 value
   function automatic logic [7:0] to_bcd(input logic [6:0] v);
      logic [3:0] tens;
      logic [3:0] ones;
      tens = 4'(v / 7'd10);
      ones = 4'(v % 7'd10);
      return {tens, ones};
   endfunction

   // Candidate mole cell from the LFSR state
   function automatic logic [2:0] mod5(input logic [7:0] v);
      return 3'(v % 8'd5);
   endfunction

endpackage

// File: rtl/mole_game_ctrl_debounce.sv
// Per-button synchroniser, stable-level filter and rising-edge press pulse.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clock,
   input  logic rst,
   input  logic raw,
   output logic press
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1;
   logic             sync2;
   logic             level;
   logic [CNT_W-1:0] cnt;

   // Synchronise, count equal samples against the accepted level, pulse on accepted rise
   always_ff @(posedge clock) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         level <= 1'b0;
         cnt   <= '0;
         press <= 1'b0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         press <= 1'b0;
         if (sync2 == level) begin
            cnt <= '0;
         end else if (cnt == LAST) begin
            level <= sync2;
            cnt   <= '0;
            press <= sync2;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/mole_game_ctrl.sv
// Game logic: debounced buttons, IDLE/RUN/OVER FSM, mole picker, hit judge, score/timer and BCD.
module mole_game_ctrl
   import mole_game_pkg::*;
#(
   parameter int         DEBOUNCE_CYCLES    = 1_000_000,
   parameter int         MOLE_PERIOD_CYCLES = 100_000_000,
   parameter int         GAME_SECONDS       = 30,
   parameter int         SCORE_MAX          = 99,
   parameter logic [7:0] LFSR_SEED          = 8'hA5
) (
   input  logic       clock,
   input  logic       rst,
   input  logic       btn_up,
   input  logic       btn_left,
   input  logic       btn_middle,
   input  logic       btn_right,
   input  logic       btn_down,
   output logic [2:0] mole_pos,
   output logic       mole_valid,
   output logic       mole_hit,
   output logic [1:0] game_state,
   output logic [6:0] score,
   output logic [5:0] time_left,
   output logic [7:0] score_bcd,
   output logic [7:0] time_bcd
);

   localparam int PER_W = (MOLE_PERIOD_CYCLES > 1) ? $clog2(MOLE_PERIOD_CYCLES) : 1;
   localparam logic [PER_W-1:0] PER_LAST  = PER_W'(MOLE_PERIOD_CYCLES - 1);
   localparam logic [6:0]       SCORE_TOP = 7'(SCORE_MAX);
   localparam logic [5:0]       TIME_INIT = 6'(GAME_SECONDS);

   game_state_t          state;
   logic [NUM_POS-1:0]   raw;
   logic [NUM_POS-1:0]   press;
   logic [7:0]           lfsr;
   logic [PER_W-1:0]     tick_cnt;
   logic                 tick;
   logic [2:0]           cand;
   logic [2:0]           next_mole;
   logic                 hit;
   logic [6:0]           score_inc;

   assign raw[BTN_UP]     = btn_up;
   assign raw[BTN_LEFT]   = btn_left;
   assign raw[BTN_MIDDLE] = btn_middle;
   assign raw[BTN_RIGHT]  = btn_right;
   assign raw[BTN_DOWN]   = btn_down;

   for (genvar i = 0; i < NUM_POS; i++) begin : g_btn
      btn_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_deb (
         .clock(clock),
         .rst  (rst),
         .raw  (raw[i]),
         .press(press[i])
      );
   end

   assign game_state = state;

   // Tick, next-mole choice (never repeats the current cell) and hit decision
   always_comb begin
      tick      = (tick_cnt == PER_LAST);
      cand      = mod5(lfsr);
      next_mole = cand;
      if (cand == mole_pos) begin
         next_mole = (cand == POS_DOWN) ? POS_UP : cand + 3'd1;
      end
      hit       = $onehot(press) && press[mole_pos] && !mole_hit;
      score_inc = (score >= SCORE_TOP) ? SCORE_TOP : score + 7'd1;
   end

   // Free-running LFSR, advances in every state
   always_ff @(posedge clock) begin
      if (rst) begin
         lfsr <= LFSR_SEED;
      end else begin
         lfsr <= {lfsr[6:0], ^(lfsr & LFSR_TAPS)};
      end
   end

   // Game FSM with tick counter, mole, score and countdown
   always_ff @(posedge clock) begin
      if (rst) begin
         state      <= ST_IDLE;
         tick_cnt   <= '0;
         mole_pos   <= POS_UP;
         mole_valid <= 1'b0;
         mole_hit   <= 1'b0;
         score      <= '0;
         time_left  <= TIME_INIT;
      end else begin
         case (state)
            ST_IDLE: begin
               tick_cnt <= '0;
               if (|press) begin
                  state      <= ST_RUN;
                  time_left  <= TIME_INIT;
                  score      <= '0;
                  mole_valid <= 1'b1;
                  mole_hit   <= 1'b0;
                  mole_pos   <= next_mole;
               end
            end
            ST_RUN: begin
               // Judge against the mole shown before any tick on this cycle
               if (hit) begin
                  score    <= score_inc;
                  mole_hit <= 1'b1;
               end
               if (tick) begin
                  tick_cnt <= '0;
                  mole_pos <= next_mole;
                  mole_hit <= 1'b0;
                  if (time_left != '0) begin
                     time_left <= time_left - 6'd1;
                  end
                  if (time_left <= 6'd1) begin
                     state      <= ST_OVER;
                     mole_valid <= 1'b0;
                  end
               end else begin
                  tick_cnt <= tick_cnt + 1'b1;
               end
            end
            ST_OVER: begin
               tick_cnt <= '0;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Display digits, one cycle behind the binary values
   always_ff @(posedge clock) begin
      if (rst) begin
         score_bcd <= 8'h00;
         time_bcd  <= to_bcd(7'(GAME_SECONDS));
      end else begin
         score_bcd <= to_bcd(score);
         time_bcd  <= to_bcd({1'b0, time_left});
      end
   end

endmodule

// File: tb/tb_mole_game_ctrl.sv
// Scoreboard bench for mole_game_ctrl: expectations queued by cycle, monitor compares on negedge.
module tb_mole_game_ctrl;

  localparam int D = 4;
  localparam int P = 20;

  localparam int S_STATE = 0, S_SCORE = 1, S_TIME = 2, S_VALID = 3;
  localparam int S_HIT = 4, S_POS = 5, S_SBCD = 6, S_TBCD = 7;
  localparam int B2 = 8;

  logic       clock = 1'b0;
  logic       rst   = 1'b1;
  logic       rst2  = 1'b1;
  logic [4:0] btn   = '0;
  logic [4:0] btn2  = '0;

  logic [2:0] pos1, pos2;
  logic       valid1, valid2, hit1, hit2;
  logic [1:0] st1, st2;
  logic [6:0] sc1, sc2;
  logic [5:0] tl1, tl2;
  logic [7:0] sb1, sb2, tb1, tb2;

  mole_game_ctrl #(
    .DEBOUNCE_CYCLES(D), .MOLE_PERIOD_CYCLES(P), .GAME_SECONDS(3),
    .SCORE_MAX(99), .LFSR_SEED(8'hA5)
  ) dut (
    .clock(clock), .rst(rst),
    .btn_up(btn[0]), .btn_left(btn[1]), .btn_middle(btn[2]),
    .btn_right(btn[3]), .btn_down(btn[4]),
    .mole_pos(pos1), .mole_valid(valid1), .mole_hit(hit1), .game_state(st1),
    .score(sc1), .time_left(tl1), .score_bcd(sb1), .time_bcd(tb1)
  );

  mole_game_ctrl #(
    .DEBOUNCE_CYCLES(D), .MOLE_PERIOD_CYCLES(P), .GAME_SECONDS(59),
    .SCORE_MAX(3), .LFSR_SEED(8'hA5)
  ) dut2 (
    .clock(clock), .rst(rst2),
    .btn_up(btn2[0]), .btn_left(btn2[1]), .btn_middle(btn2[2]),
    .btn_right(btn2[3]), .btn_down(btn2[4]),
    .mole_pos(pos2), .mole_valid(valid2), .mole_hit(hit2), .game_state(st2),
    .score(sc2), .time_left(tl2), .score_bcd(sb2), .time_bcd(tb2)
  );

  always #5 clock = ~clock;

  typedef struct {
    int    cyc;
    int    sig;
    int    exp;
    string name;
  } exp_t;

  exp_t sb[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Queue an expectation, kept sorted by cycle
  task automatic expect_at(input int c, input int sig, input int v, input string nm);
    exp_t e;
    int   i;
    e.cyc = c; e.sig = sig; e.exp = v; e.name = nm;
    i = 0;
    while (i < sb.size() && sb[i].cyc <= c) i++;
    sb.insert(i, e);
  endtask

  function automatic int actual(input int sig);
    case (sig)
      S_STATE:      return int'(st1);
      S_SCORE:      return int'(sc1);
      S_TIME:       return int'(tl1);
      S_VALID:      return int'(valid1);
      S_HIT:        return int'(hit1);
      S_POS:        return int'(pos1);
      S_SBCD:       return int'(sb1);
      S_TBCD:       return int'(tb1);
      B2 + S_STATE: return int'(st2);
      B2 + S_SCORE: return int'(sc2);
      B2 + S_TIME:  return int'(tl2);
      B2 + S_VALID: return int'(valid2);
      B2 + S_HIT:   return int'(hit2);
      B2 + S_POS:   return int'(pos2);
      B2 + S_SBCD:  return int'(sb2);
      B2 + S_TBCD:  return int'(tb2);
      default:      return -1;
    endcase
  endfunction

  // Monitor: compare every expectation due at this cycle
  always @(negedge clock) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      int   a;
      e = sb.pop_front();
      a = actual(e.sig);
      total++;
      if (e.cyc != cyc || a != e.exp) begin
        bad++;
        $display("FAIL %s cyc=%0d (due %0d): got %0d expected %0d", e.name, cyc, e.cyc, a, e.exp);
      end
    end
  end

  // Reference mole picker
  function automatic logic [7:0] lstep(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic logic [7:0] lfsr_after(input int n);
    logic [7:0] v;
    v = 8'hA5;
    for (int k = 0; k < n; k++) v = lstep(v);
    return v;
  endfunction

  function automatic int pick(input logic [7:0] l, input int prev);
    int c;
    c = int'(l) % 5;
    if (c == prev) c = (c + 1) % 5;
    return c;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic goto(input int c);
    while (cyc < c) step();
  endtask

  task automatic press(input bit second, input logic [4:0] m, input int c, input int hold);
    goto(c);
    if (second) btn2 = m; else btn = m;
    goto(c + hold);
    if (second) btn2 = '0; else btn = '0;
  endtask

  int m1, m2, m3;
  int mk [4];

  initial begin
    // Reset two cycles; reset state visible at cycle 2
    step(); step();
    total++;
    if (st1 !== 2'd0) begin
      bad++;
      $display("FAIL direct_rst_state: got %0d expected 0", st1);
    end
    total++;
    if (tl1 !== 6'd3) begin
      bad++;
      $display("FAIL direct_rst_time: got %0d expected 3", tl1);
    end
    total++;
    if (tb1 !== 8'h03) begin
      bad++;
      $display("FAIL direct_rst_time_bcd: got %0h expected 03", tb1);
    end
    rst = 1'b0;
    expect_at(2, S_STATE, 0, "rst_state");
    expect_at(2, S_SCORE, 0, "rst_score");
    expect_at(2, S_TIME, 3, "rst_time");
    expect_at(2, S_TBCD, 8'h03, "rst_time_bcd");
    expect_at(2, S_SBCD, 8'h00, "rst_score_bcd");
    expect_at(2, S_VALID, 0, "rst_valid");
    expect_at(2, S_HIT, 0, "rst_hit");
    expect_at(2, S_POS, 0, "rst_pos");

    // LFSR resets at edge 2; moles chosen at edges 21, 41, 61
    m1 = pick(lfsr_after(18), 0);
    m2 = pick(lfsr_after(38), m1);
    m3 = pick(lfsr_after(58), m2);

    expect_at(13, S_STATE, 0, "glitch_ignored");
    expect_at(20, S_STATE, 0, "start_not_early");
    expect_at(21, S_STATE, 1, "start_run");
    expect_at(21, S_VALID, 1, "start_valid");
    expect_at(21, S_HIT, 0, "start_hit");
    expect_at(21, S_TIME, 3, "start_time");
    expect_at(21, S_POS, m1, "mole1");
    expect_at(40, S_TIME, 3, "time_pre_tick1");
    expect_at(41, S_TIME, 2, "time_tick1");
    expect_at(41, S_POS, m2, "mole2");
    expect_at(42, S_TBCD, 8'h02, "time_bcd_tick1");
    expect_at(42, S_SCORE, 0, "score_before_hit");
    expect_at(42, S_HIT, 0, "hit_before");
    expect_at(43, S_HIT, 1, "hit_set");
    expect_at(43, S_SCORE, 1, "score_hit");
    expect_at(44, S_SBCD, 8'h01, "score_bcd_hit");
    expect_at(53, S_SCORE, 1, "repeat_hit_score");
    expect_at(53, S_HIT, 1, "repeat_hit_flag");
    expect_at(61, S_TIME, 1, "time_tick2");
    expect_at(61, S_POS, m3, "mole3");
    expect_at(61, S_HIT, 0, "hit_clear_tick");
    expect_at(63, S_SCORE, 1, "wrong_btn_score");
    expect_at(63, S_HIT, 0, "wrong_btn_hit");
    expect_at(71, S_SCORE, 1, "mash_score");
    expect_at(71, S_HIT, 0, "mash_hit");
    expect_at(80, S_STATE, 1, "run_pre_final");
    expect_at(80, S_VALID, 1, "valid_pre_final");
    expect_at(81, S_SCORE, 2, "final_tick_hit");
    expect_at(81, S_STATE, 2, "over_state");
    expect_at(81, S_VALID, 0, "over_valid");
    expect_at(81, S_TIME, 0, "over_time");
    expect_at(81, S_HIT, 0, "over_hit");
    expect_at(82, S_SBCD, 8'h02, "over_score_bcd");
    expect_at(82, S_TBCD, 8'h00, "over_time_bcd");
    expect_at(95, S_SCORE, 2, "over_press_score");
    expect_at(95, S_STATE, 2, "over_hold");

    // Glitch on middle, then a proper 10-cycle press
    btn[2] = 1'b1;
    goto(5);
    btn[2] = 1'b0;
    press(1'b0, 5'b00100, 14, 10);
    // Correct hit, then a repeat on the same mole
    press(1'b0, 5'(1 << m2), 36, 4);
    press(1'b0, 5'(1 << m2), 46, 4);
    // Wrong button, then correct plus another together
    press(1'b0, 5'(1 << ((m3 + 1) % 5)), 56, 4);
    press(1'b0, 5'((1 << m3) | (1 << ((m3 + 2) % 5))), 64, 4);
    // Correct press judged on the final tick
    press(1'b0, 5'(1 << m3), 74, 4);
    // Press during OVER
    press(1'b0, 5'b00001, 86, 4);

    // Second instance: 59 s game, low saturation limit
    goto(100);
    rst2 = 1'b0;
    for (int k = 0; k < 4; k++)
      mk[k] = pick(lfsr_after(7 + 20 * k), (k == 0) ? 0 : mk[k - 1]);
    expect_at(100, B2 + S_TIME, 59, "d2_rst_time");
    expect_at(100, B2 + S_TBCD, 8'h59, "d2_rst_time_bcd");
    expect_at(108, B2 + S_STATE, 1, "d2_start");
    for (int k = 0; k < 4; k++)
      expect_at(108 + 20 * k, B2 + S_POS, mk[k], "d2_mole");
    expect_at(117, B2 + S_SCORE, 0, "d2_score0");
    expect_at(118, B2 + S_SCORE, 1, "d2_score1");
    expect_at(118, B2 + S_HIT, 1, "d2_hit1");
    expect_at(128, B2 + S_TIME, 58, "d2_time_tick");
    expect_at(129, B2 + S_TBCD, 8'h58, "d2_time_bcd_tick");
    expect_at(138, B2 + S_SCORE, 2, "d2_score2");
    expect_at(158, B2 + S_SCORE, 3, "d2_score_max");
    expect_at(159, B2 + S_SBCD, 8'h03, "d2_score_bcd_max");
    expect_at(178, B2 + S_SCORE, 3, "d2_score_sat");
    expect_at(186, B2 + S_STATE, 0, "d2_rst_state");
    expect_at(186, B2 + S_SCORE, 0, "d2_rst_score");
    expect_at(186, B2 + S_TIME, 59, "d2_rst_time2");
    expect_at(186, B2 + S_VALID, 0, "d2_rst_valid");
    expect_at(186, B2 + S_HIT, 0, "d2_rst_hit");
    expect_at(186, B2 + S_POS, 0, "d2_rst_pos");
    expect_at(186, B2 + S_SBCD, 8'h00, "d2_rst_score_bcd");
    expect_at(186, B2 + S_TBCD, 8'h59, "d2_rst_time_bcd2");

    press(1'b1, 5'b00001, 101, 4);
    for (int k = 0; k < 4; k++)
      press(1'b1, 5'(1 << mk[k]), 111 + 20 * k, 4);
    goto(185);
    rst2 = 1'b1;
    step();
    rst2 = 1'b0;
    goto(195);
    @(negedge clock);
    #1;
    total++;
    if (st1 !== 2'd2) begin
      bad++;
      $display("FAIL direct_over_state: got %0d expected 2", st1);
    end
    total++;
    if (sc1 !== 7'd2) begin
      bad++;
      $display("FAIL direct_over_score: got %0d expected 2", sc1);
    end
    total++;
    if (valid1 !== 1'b0) begin
      bad++;
      $display("FAIL direct_over_valid: got %0d expected 0", valid1);
    end
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      total++;
      bad++;
      $display("FAIL %s: not reached, expected %0d at cycle %0d", e.name, e.exp, e.cyc);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
